// File: rtl/digit_demux4_if.sv
// ---------------------------------------------------------------------------
// digit_demux4_if
//
// Bundles the beat source handshake and the committed frame outputs of
// digit_demux4 into one interface.
//
//   in_valid   source presents a beat on in_data
//   in_sof     beat is slot 0 (start of frame)
//   in_data    slot data for the current beat (W bits)
//   in_ready   block can accept a beat this cycle
//   A, B, C, D committed slot 0..3 values (W bits each)
//   frame_done one-cycle pulse when A..D update
//   err_sof    one-cycle pulse on a frame protocol error
//   slot       index of the next slot to be filled
//   frame_cnt  number of committed frames, wraps 255 -> 0
//
// The master modport is the beat source (and observer of the results).
// The slave modport is the demultiplexer itself.
// ---------------------------------------------------------------------------
interface digit_demux4_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_sof;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] C;
    logic [W-1:0] D;
    logic         frame_done;
    logic         err_sof;
    logic [1:0]   slot;
    logic [7:0]   frame_cnt;

    modport master (
        output in_valid,
        output in_sof,
        output in_data,
        input  in_ready,
        input  A,
        input  B,
        input  C,
        input  D,
        input  frame_done,
        input  err_sof,
        input  slot,
        input  frame_cnt
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_data,
        output in_ready,
        output A,
        output B,
        output C,
        output D,
        output frame_done,
        output err_sof,
        output slot,
        output frame_cnt
    );
endinterface

// File: rtl/digit_demux4.sv
// ---------------------------------------------------------------------------
// digit_demux4
//
// Collects four W-bit beats (slot 0 marked by in_sof) into a shadow
// register and, once a full frame has arrived, commits all four slots to
// the registered outputs A..D in a single cycle.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  digit_demux4_if.slave
//          in_valid / in_sof / in_data  beat input
//          in_ready                     accept qualifier (low in COMMIT
//                                       and while rst is high)
//          A, B, C, D                   committed slots
//          frame_done, err_sof          one-cycle event pulses
//          slot                         next slot to be filled
//          frame_cnt                    committed frame counter
//
// Frame protocol:
//   IDLE    waits for a start-of-frame beat; a beat without in_sof is
//           dropped and flagged on err_sof.
//   COLLECT fills slots 1..3; a fresh in_sof restarts the frame at slot 0
//           (flagged on err_sof) so a partial frame is never committed.
//   COMMIT  one cycle with in_ready low; its closing edge copies the
//           shadow into A..D, pulses frame_done and bumps frame_cnt.
// ---------------------------------------------------------------------------
module digit_demux4 #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    digit_demux4_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic [1:0]   slot_q;
    logic [1:0]   slot_d;
    logic [W-1:0] shadow_q [4];
    logic [W-1:0] shadow_d [4];
    logic [W-1:0] a_q;
    logic [W-1:0] a_d;
    logic [W-1:0] b_q;
    logic [W-1:0] b_d;
    logic [W-1:0] c_q;
    logic [W-1:0] c_d;
    logic [W-1:0] d_q;
    logic [W-1:0] d_d;
    logic         frame_done_q;
    logic         frame_done_d;
    logic         err_sof_q;
    logic         err_sof_d;
    logic [7:0]   frame_cnt_q;
    logic [7:0]   frame_cnt_d;

    logic         in_ready;
    logic         accept;

    // A beat only counts on an edge where both sides agree; every shadow
    // and slot update below is gated by this.
    assign accept = bus.in_valid && in_ready;

    // -----------------------------------------------------------------------
    // FSM state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic. A restart (in_sof while collecting) keeps us in
    // COLLECT; only a non-sof beat landing in slot 3 moves on to COMMIT,
    // which always lasts exactly one cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.in_sof) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && !bus.in_sof && (slot_q == 2'd3)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM output logic. in_ready is held low during reset so the source
    // cannot believe a beat was taken while the block is being cleared.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        if (!rst && (state_q != COMMIT)) begin
            in_ready = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next-state logic. Everything holds by default and the two
    // event pulses default low so they last exactly one cycle. The slot
    // counter is two bits wide, so advancing from 3 wraps back to 0 as the
    // frame heads into COMMIT.
    // -----------------------------------------------------------------------
    always_comb begin
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        err_sof_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        shadow_d[0] = bus.in_data;
                        slot_d      = 2'd1;
                    end else begin
                        err_sof_d   = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        shadow_d[0] = bus.in_data;
                        slot_d      = 2'd1;
                        err_sof_d   = 1'b1;
                    end else begin
                        shadow_d[slot_q] = bus.in_data;
                        slot_d           = slot_q + 2'd1;
                    end
                end
            end
            COMMIT: begin
                a_d          = shadow_q[0];
                b_d          = shadow_q[1];
                c_d          = shadow_q[2];
                d_d          = shadow_q[3];
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
            end
            default: begin
                slot_d = 2'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. Reset clears the committed outputs as well as the
    // shadow, so an interrupted frame never leaves stale data on A..D.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            slot_q       <= slot_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.C          = c_q;
    assign bus.D          = d_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err_sof    = err_sof_q;
    assign bus.slot       = slot_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule
